// File: rtl/bp_mem_model_pkg.sv
// Shared types and geometry helpers for the block backing store.
// The FSM state enum and the address-split helpers live here.
package bp_mem_model_pkg;

    typedef enum logic [1:0] {
        e_init,
        e_ready,
        e_wait,
        e_resp
    } bp_mem_model_state_e;

    // Byte-offset bits inside one block.
    function automatic int blk_off_f(input int block_width);
        return $clog2(block_width / 8);
    endfunction

    function automatic int idx_width_f(input int mem_els);
        return $clog2(mem_els);
    endfunction

endpackage

// File: rtl/bp_mem_block_backing_store_array.sv
// Block storage with one byte-masked synchronous write port and one async read port.
// Storage is split per byte lane so every lane owns its own write enable.
module bp_mem_block_backing_store_array
    import bp_mem_model_pkg::*;
#(
    parameter int block_width_p = 512,
    parameter int mem_els_p     = 64,
    localparam int idx_w_lp     = idx_width_f(mem_els_p),
    localparam int bytes_lp     = block_width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [idx_w_lp-1:0]      w_idx_i,
    input  logic [block_width_p-1:0] w_data_i,
    input  logic [bytes_lp-1:0]      w_mask_i,
    input  logic                     zero_v_i,
    input  logic [idx_w_lp-1:0]      zero_idx_i,
    input  logic [idx_w_lp-1:0]      r_idx_i,
    output logic [block_width_p-1:0] r_data_o
);

    for (genvar b = 0; b < bytes_lp; b++) begin : g_lane
        logic [7:0] lane_q [mem_els_p];

        // Zero-fill and masked writes never coincide; zero-fill wins if they did.
        always_ff @(posedge clk_i) begin
            if (zero_v_i) begin
                lane_q[zero_idx_i] <= 8'h00;
            end else if (w_v_i && w_mask_i[b]) begin
                lane_q[w_idx_i] <= w_data_i[8*b +: 8];
            end
        end

        assign r_data_o[8*b +: 8] = lane_q[r_idx_i];
    end

endmodule

// File: rtl/bp_mem_block_backing_store.sv
// Single-outstanding block backing store: zero-fills after reset, then serves one
// masked write or read at a time with a fixed accept-to-response latency.
module bp_mem_block_backing_store
    import bp_mem_model_pkg::*;
#(
    parameter int paddr_width_p = 40,
    parameter int block_width_p = 512,
    parameter int mem_els_p     = 64,
    parameter int latency_p     = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    output logic                       ready_o,
    input  logic                       v_i,
    input  logic                       w_i,
    input  logic [paddr_width_p-1:0]   addr_i,
    input  logic [block_width_p-1:0]   data_i,
    input  logic [block_width_p/8-1:0] write_mask_i,
    output logic [block_width_p-1:0]   data_o,
    output logic                       v_o,
    input  logic                       yumi_i
);

    localparam int blk_off_lp = blk_off_f(block_width_p);
    localparam int idx_w_lp   = idx_width_f(mem_els_p);
    localparam int bytes_lp   = block_width_p / 8;
    localparam int cnt_w_lp   = $clog2(latency_p + 1);

    localparam logic [cnt_w_lp-1:0] cnt_init_lp = cnt_w_lp'(latency_p - 1);
    localparam logic [idx_w_lp-1:0] idx_last_lp = idx_w_lp'(mem_els_p - 1);

    bp_mem_model_state_e        state_q;
    logic [idx_w_lp-1:0]        init_idx_q;
    logic [cnt_w_lp-1:0]        cnt_q;
    logic [block_width_p-1:0]   data_q;
    logic                       ready_q;
    logic                       v_q;

    logic [idx_w_lp-1:0]        cmd_idx;
    logic [block_width_p-1:0]   rd_blk;
    logic [block_width_p-1:0]   resp_d;
    logic                       arr_w_v;
    logic                       arr_zero_v;

    // Upper address bits alias and the in-block offset is dropped.
    assign cmd_idx = addr_i[blk_off_lp +: idx_w_lp];

    logic unused_addr;
    assign unused_addr = ^{addr_i[paddr_width_p-1:blk_off_lp+idx_w_lp], addr_i[blk_off_lp-1:0]};

    // A command is only ever taken in e_ready, where ready_q is set.
    assign arr_w_v    = reset_n_i & ready_q & v_i & w_i;
    assign arr_zero_v = reset_n_i & (state_q == e_init);

    bp_mem_block_backing_store_array #(
        .block_width_p (block_width_p),
        .mem_els_p     (mem_els_p)
    ) u_array (
        .clk_i      (clk_i),
        .w_v_i      (arr_w_v),
        .w_idx_i    (cmd_idx),
        .w_data_i   (data_i),
        .w_mask_i   (write_mask_i),
        .zero_v_i   (arr_zero_v),
        .zero_idx_i (init_idx_q),
        .r_idx_i    (cmd_idx),
        .r_data_o   (rd_blk)
    );

    // Writes answer with the post-write block, so merge the masked bytes here.
    always_comb begin
        resp_d = rd_blk;
        if (w_i) begin
            for (int b = 0; b < bytes_lp; b++) begin
                if (write_mask_i[b]) begin
                    resp_d[8*b +: 8] = data_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q    <= e_init;
            init_idx_q <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            ready_q    <= 1'b0;
            v_q        <= 1'b0;
        end else begin
            case (state_q)
                e_init: begin
                    init_idx_q <= init_idx_q + 1'b1;
                    if (init_idx_q == idx_last_lp) begin
                        state_q <= e_ready;
                        ready_q <= 1'b1;
                    end
                end
                e_ready: begin
                    if (v_i) begin
                        ready_q <= 1'b0;
                        data_q  <= resp_d;
                        cnt_q   <= cnt_init_lp;
                        if (latency_p == 1) begin
                            state_q <= e_resp;
                            v_q     <= 1'b1;
                        end else begin
                            state_q <= e_wait;
                        end
                    end
                end
                e_wait: begin
                    if (cnt_q == '0) begin
                        state_q <= e_resp;
                        v_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                e_resp: begin
                    if (yumi_i) begin
                        state_q <= e_ready;
                        v_q     <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= e_init;
            endcase
        end
    end

    assign ready_o = ready_q;
    assign v_o     = v_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_bp_mem_block_backing_store.sv
// Randomized bench for the block backing store against a flat array model.
// Each scenario task drives stimulus and checks its own results inline.
module tb_bp_mem_block_backing_store;

    localparam int AW  = 40;
    localparam int BW  = 512;
    localparam int NB  = BW / 8;
    localparam int ELS = 64;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          reset_n_i = 1'b0;
    logic          ready_o, v_o;
    logic          v_i = 1'b0, w_i = 1'b0, yumi_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [BW-1:0] data_i = '0, data_o;
    logic [NB-1:0] write_mask_i = '0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [BW-1:0] ref_mem [ELS];

    always #5 clk = ~clk;

    bp_mem_block_backing_store #(
        .paddr_width_p (AW),
        .block_width_p (BW),
        .mem_els_p     (ELS),
        .latency_p     (LAT)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n_i),
        .ready_o      (ready_o),
        .v_i          (v_i),
        .w_i          (w_i),
        .addr_i       (addr_i),
        .data_i       (data_i),
        .write_mask_i (write_mask_i),
        .data_o       (data_o),
        .v_o          (v_o),
        .yumi_i       (yumi_i)
    );

    // Reference: block number is the byte address divided by block size, modulo depth.
    function automatic logic [BW-1:0] model_access(input logic w, input logic [AW-1:0] addr,
                                                   input logic [BW-1:0] data, input logic [NB-1:0] mask);
        int idx = int'((addr / NB) % ELS);
        if (w) begin
            for (int b = 0; b < NB; b++) begin
                if (mask[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
        return ref_mem[idx];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < ELS; i++) ref_mem[i] = '0;
    endfunction

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] r;
        for (int i = 0; i < BW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Drives one transaction from posedge+1 timing; yumis as soon as v_o appears.
    task automatic do_txn(input logic w, input logic [AW-1:0] addr, input logic [BW-1:0] data,
                          input logic [NB-1:0] mask, output logic [BW-1:0] got, output int lat,
                          output bit ok, output logic rdy_after);
        int n = 0;
        ok = 1'b1; lat = 0; got = '0; rdy_after = 1'b0;
        while (!ready_o && n < 200) begin @(posedge clk); #1; n++; end
        if (!ready_o) begin ok = 1'b0; return; end
        v_i = 1'b1; w_i = w; addr_i = addr; data_i = data; write_mask_i = mask;
        @(posedge clk); #1;
        v_i = 1'b0; w_i = 1'b0; data_i = rand_blk();
        while (!v_o && lat < 50) begin @(posedge clk); #1; lat++; end
        if (!v_o) begin ok = 1'b0; return; end
        got = data_o;
        yumi_i = 1'b1;
        @(posedge clk); #1;
        yumi_i = 1'b0;
        rdy_after = ready_o;
    endtask

    task automatic test_reset();
        int n = 0;
        logic [BW-1:0] got; int lat; bit ok; logic rdy;
        reset_n_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({ready_o, v_o} !== 2'b00 || data_o !== '0) $display("FAIL reset_outputs: ready=%b v=%b data=%h", ready_o, v_o, data_o);
        else n_pass++;
        reset_n_i = 1'b1;
        model_clear();
        while (!ready_o && n < 200) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (n !== ELS) $display("FAIL init_cycles: got %0d exp %0d", n, ELS);
        else n_pass++;
        do_txn(1'b0, 40'h0, '0, '0, got, lat, ok, rdy);
        n_checks++;
        if (!ok || lat !== LAT || got !== '0) $display("FAIL reset_read: ok=%0d lat=%0d exp %0d data=%h", ok, lat, LAT, got);
        else n_pass++;
    endtask

    task automatic test_full_write();
        logic [BW-1:0] p, got, exp; int lat; bit ok; logic rdy;
        for (int i = 0; i < 16; i++) p[32*i +: 32] = 32'hA5A5_0000 + i;
        exp = model_access(1'b1, 40'h40, p, '1);
        do_txn(1'b1, 40'h40, p, '1, got, lat, ok, rdy);
        n_checks++;
        if (!ok || lat !== LAT || got !== exp) $display("FAIL full_write_resp: lat=%0d got %h exp %h", lat, got, exp);
        else n_pass++;
        n_checks++;
        if (rdy !== 1'b1) $display("FAIL ready_after_yumi: got %b exp 1", rdy);
        else n_pass++;
        exp = model_access(1'b0, 40'h40, '0, '0);
        do_txn(1'b0, 40'h40, '0, '0, got, lat, ok, rdy);
        n_checks++;
        if (!ok || got !== p) $display("FAIL full_write_read: got %h exp %h", got, p);
        else n_pass++;
    endtask

    task automatic test_partial_write();
        logic [BW-1:0] d, got, exp; int lat; bit ok; logic rdy;
        d = rand_blk();
        d[127:64] = 64'hDEAD_BEEF_CAFE_F00D;
        exp = '0;
        exp[127:64] = 64'hDEAD_BEEF_CAFE_F00D;
        void'(model_access(1'b1, 40'h80, d, 64'h0000_0000_0000_FF00));
        do_txn(1'b1, 40'h80, d, 64'h0000_0000_0000_FF00, got, lat, ok, rdy);
        do_txn(1'b0, 40'h80, '0, '0, got, lat, ok, rdy);
        n_checks++;
        if (!ok || got !== exp) $display("FAIL partial_write: got %h exp %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] exp, held, got; int lat = 0; bit ok, bad = 1'b0; logic rdy;
        exp = model_access(1'b0, 40'h40, '0, '0);
        v_i = 1'b1; w_i = 1'b0; addr_i = 40'h40;
        @(posedge clk); #1;
        // Second command: a full-mask write elsewhere that must not be taken.
        w_i = 1'b1; addr_i = 40'h100; data_i = rand_blk(); write_mask_i = '1;
        while (!v_o && lat < 50) begin @(posedge clk); #1; lat++; end
        n_checks++;
        if (lat !== LAT) $display("FAIL bp_latency: got %0d exp %0d", lat, LAT);
        else n_pass++;
        held = data_o;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (v_o !== 1'b1 || ready_o !== 1'b0 || data_o !== held) bad = 1'b1;
        end
        n_checks++;
        if (bad || held !== exp) $display("FAIL backpressure_hold: bad=%0d data %h exp %h", bad, held, exp);
        else n_pass++;
        v_i = 1'b0; w_i = 1'b0; yumi_i = 1'b1;
        @(posedge clk); #1;
        yumi_i = 1'b0;
        n_checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0) $display("FAIL bp_release: ready=%b v=%b exp 1/0", ready_o, v_o);
        else n_pass++;
        exp = model_access(1'b0, 40'h100, '0, '0);
        do_txn(1'b0, 40'h100, '0, '0, got, lat, ok, rdy);
        n_checks++;
        if (!ok || got !== exp) $display("FAIL bp_no_accept: got %h exp %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_alias();
        logic [BW-1:0] p, got; int lat; bit ok; logic rdy;
        p = rand_blk();
        void'(model_access(1'b1, 40'h1040, p, '1));
        do_txn(1'b1, 40'h1040, p, '1, got, lat, ok, rdy);
        do_txn(1'b0, 40'h40, '0, '0, got, lat, ok, rdy);
        n_checks++;
        if (!ok || got !== p) $display("FAIL alias: got %h exp %h", got, p);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [BW-1:0] d, got, exp; logic [AW-1:0] a; logic [NB-1:0] m;
        int lat; bit ok; logic w, rdy;
        for (int t = 0; t < 40; t++) begin
            w = 1'($urandom_range(0, 1));
            a = {8'($urandom), $urandom};
            if (t % 4 == 0) a = a & 40'h0000_0003_FF; // crowd a few blocks to exercise overwrites
            d = rand_blk();
            m = {$urandom, $urandom};
            exp = model_access(w, a, d, m);
            do_txn(w, a, d, m, got, lat, ok, rdy);
            n_checks++;
            if (!ok || lat !== LAT || got !== exp || rdy !== 1'b1)
                $display("FAIL random[%0d]: w=%b a=%h lat=%0d rdy=%b got %h exp %h", t, w, a, lat, rdy, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] got; int lat, n = 0; bit ok, saw_v = 1'b0; logic rdy;
        void'(model_access(1'b1, 40'hC0, '1, '1));
        do_txn(1'b1, 40'hC0, '1, '1, got, lat, ok, rdy);
        v_i = 1'b1; w_i = 1'b0; addr_i = 40'hC0;
        @(posedge clk); #1;
        v_i = 1'b0;
        @(posedge clk); #1;
        reset_n_i = 1'b0;
        @(posedge clk); #1;
        reset_n_i = 1'b1;
        model_clear();
        if (v_o) saw_v = 1'b1;
        while (!ready_o && n < 200) begin @(posedge clk); #1; n++; if (v_o) saw_v = 1'b1; end
        repeat (LAT + 2) begin @(posedge clk); #1; if (v_o) saw_v = 1'b1; end
        n_checks++;
        if (saw_v || n !== ELS) $display("FAIL reset_mid: v_seen=%0d init_cycles=%0d exp 0/%0d", saw_v, n, ELS);
        else n_pass++;
        do_txn(1'b0, 40'hC0, '0, '0, got, lat, ok, rdy);
        n_checks++;
        if (!ok || got !== model_access(1'b0, 40'hC0, '0, '0)) $display("FAIL reset_mid_read: got %h exp 0", got);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_partial_write();
        test_backpressure();
        test_alias();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
